// File: rtl/read_iq_multi_if.sv
// Port bundle for the IQ unpacker: input FIFO pop side, paired I/Q FIFO push side and status.
// The master modport is the unpacker's view; slave is the surrounding FIFO/control side.
interface read_iq_multi_if #(
    parameter int unsigned PAIRS_PER_WORD = 1,
    parameter int unsigned OUT_W          = 32
);
    localparam int unsigned IN_W = 32 * PAIRS_PER_WORD;

    logic             in_rd_en;
    logic             in_empty;
    logic [IN_W-1:0]  in_dout;
    logic             out_i_wr_en;
    logic             out_i_full;
    logic [OUT_W-1:0] out_i_din;
    logic             out_q_wr_en;
    logic             out_q_full;
    logic [OUT_W-1:0] out_q_din;
    logic             iq_swap;
    logic [31:0]      pair_count;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_i_wr_en,
        input  out_i_full,
        output out_i_din,
        output out_q_wr_en,
        input  out_q_full,
        output out_q_din,
        input  iq_swap,
        output pair_count
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_i_wr_en,
        output out_i_full,
        input  out_i_din,
        input  out_q_wr_en,
        output out_q_full,
        input  out_q_din,
        output iq_swap,
        input  pair_count
    );
endinterface

// File: rtl/read_iq_multi.sv
// IQ front-end unpacker: pops words of PAIRS_PER_WORD byte-swapped I/Q pairs, quantises them
// on load and streams one (I,Q) pair per cycle into the I and Q output FIFOs.
module read_iq_multi #(
    parameter int unsigned PAIRS_PER_WORD = 1,
    parameter int unsigned QUANT_BITS     = 10,
    parameter int unsigned OUT_W          = 32
) (
    input  logic           clock,
    input  logic           reset,
    read_iq_multi_if.master bus
);
    localparam int unsigned     IDX_W    = (PAIRS_PER_WORD > 1) ? $clog2(PAIRS_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS_PER_WORD - 1);

    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_EMIT = 2'b10;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [31:0]      count;

    logic [OUT_W-1:0] word_i [PAIRS_PER_WORD];
    logic [OUT_W-1:0] word_q [PAIRS_PER_WORD];
    logic [OUT_W-1:0] cap_i  [PAIRS_PER_WORD];
    logic [OUT_W-1:0] cap_q  [PAIRS_PER_WORD];
    logic [OUT_W-1:0] sel_i;
    logic [OUT_W-1:0] sel_q;

    logic out_ok;
    logic load;
    logic clear;
    logic rd;
    logic wr;

    // Samples travel little-endian within each 16-bit field.
    function automatic logic [15:0] raw_i(input logic [31:0] p);
        return {p[23:16], p[31:24]};
    endfunction

    function automatic logic [15:0] raw_q(input logic [31:0] p);
        return {p[7:0], p[15:8]};
    endfunction

    function automatic logic [OUT_W-1:0] quantise(input logic [15:0] s);
        logic [OUT_W-1:0] ext;
        ext = OUT_W'($signed(s));
        return ext << QUANT_BITS;
    endfunction

    // Quantise every pair of the word at the FIFO head, swap applied at capture time.
    always_comb begin
        for (int k = 0; k < int'(PAIRS_PER_WORD); k++) begin
            if (bus.iq_swap) begin
                cap_i[k] = quantise(raw_q(bus.in_dout[32*k +: 32]));
                cap_q[k] = quantise(raw_i(bus.in_dout[32*k +: 32]));
            end else begin
                cap_i[k] = quantise(raw_i(bus.in_dout[32*k +: 32]));
                cap_q[k] = quantise(raw_q(bus.in_dout[32*k +: 32]));
            end
        end
    end

    // Pending pair mux.
    always_comb begin
        sel_i = '0;
        sel_q = '0;
        for (int k = 0; k < int'(PAIRS_PER_WORD); k++) begin
            if (idx == IDX_W'(k)) begin
                sel_i = word_i[k];
                sel_q = word_q[k];
            end
        end
    end

    // Next-state and handshake decode; the last pair of a word reloads in the same cycle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        clear     = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        out_ok    = !bus.out_i_full && !bus.out_q_full;
        case (state)
            ST_LOAD: begin
                if (!bus.in_empty) begin
                    rd        = 1'b1;
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ok) begin
                    wr = 1'b1;
                    if (idx != LAST_IDX) begin
                        idx_nxt = idx + IDX_W'(1);
                    end else if (!bus.in_empty) begin
                        rd      = 1'b1;
                        load    = 1'b1;
                        idx_nxt = '0;
                    end else begin
                        state_nxt = ST_LOAD;
                    end
                end
            end
            default: begin
                state_nxt = ST_LOAD;
                idx_nxt   = '0;
                clear     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
            idx   <= '0;
            count <= '0;
            for (int k = 0; k < int'(PAIRS_PER_WORD); k++) begin
                word_i[k] <= '0;
                word_q[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (clear) begin
                count <= '0;
            end else if (wr) begin
                count <= count + 32'd1;
            end
            for (int k = 0; k < int'(PAIRS_PER_WORD); k++) begin
                if (clear) begin
                    word_i[k] <= '0;
                    word_q[k] <= '0;
                end else if (load) begin
                    word_i[k] <= cap_i[k];
                    word_q[k] <= cap_q[k];
                end
            end
        end
    end

    // Handshakes are forced low for the whole time reset is held.
    assign bus.in_rd_en    = rd && !reset;
    assign bus.out_i_wr_en = wr && !reset;
    assign bus.out_q_wr_en = wr && !reset;
    assign bus.out_i_din   = (wr && !reset) ? sel_i : '0;
    assign bus.out_q_din   = (wr && !reset) ? sel_q : '0;
    assign bus.pair_count  = count;

endmodule

// File: tb/tb_read_iq_multi.sv
// Bench for read_iq_multi: three instances (1, 2 and 4 pairs per word) against a queue-style model.
module tb_read_iq_multi;
    localparam int unsigned QB    = 10;
    localparam int unsigned OW    = 32;
    localparam int unsigned NI    = 3;
    localparam int unsigned DEPTH = 1024;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    read_iq_multi_if #(.PAIRS_PER_WORD(1), .OUT_W(OW)) bus0 ();
    read_iq_multi_if #(.PAIRS_PER_WORD(2), .OUT_W(OW)) bus1 ();
    read_iq_multi_if #(.PAIRS_PER_WORD(4), .OUT_W(OW)) bus2 ();

    read_iq_multi #(.PAIRS_PER_WORD(1), .QUANT_BITS(QB), .OUT_W(OW)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    read_iq_multi #(.PAIRS_PER_WORD(2), .QUANT_BITS(QB), .OUT_W(OW)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    read_iq_multi #(.PAIRS_PER_WORD(4), .QUANT_BITS(QB), .OUT_W(OW)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

    int checks = 0;
    int errors = 0;

    logic [127:0] src_mem [NI][DEPTH];
    int           src_rd  [NI];
    int           src_wr  [NI];
    logic         full_i  [NI];
    logic         full_q  [NI];
    logic         swap    [NI];

    // Model: pairs still owed from the last popped word, plus the running pair total.
    logic [OW-1:0] pend_i [NI][4];
    logic [OW-1:0] pend_q [NI][4];
    int            pend_n [NI];
    int            pend_h [NI];
    logic [31:0]   mcount [NI];
    logic          exp_rd [NI];
    logic          exp_wr [NI];
    logic [98:0]   exp_v  [NI];

    logic          obs_rd  [NI];
    logic          obs_wi  [NI];
    logic          obs_wq  [NI];
    logic [OW-1:0] obs_di  [NI];
    logic [OW-1:0] obs_dq  [NI];
    logic [31:0]   obs_cnt [NI];
    logic [98:0]   obs_v   [NI];

    function automatic int pairs_of(input int j);
        return (j == 0) ? 1 : (j == 1) ? 2 : 4;
    endfunction

    // Signed 16-bit sample from high/low bytes, scaled by 2^QB.
    function automatic logic [OW-1:0] qval(input int hi, input int lo);
        int v;
        v = hi * 256 + lo;
        if (v >= 32768) v = v - 65536;
        return OW'(longint'(v) * (longint'(1) << QB));
    endfunction

    function automatic int byte_of(input logic [31:0] p, input int n);
        return int'((p >> (8 * n)) & 32'hFF);
    endfunction

    task automatic push(input int j, input logic [127:0] w);
        src_mem[j][src_wr[j]] = w;
        src_wr[j]++;
    endtask

    task automatic drive_inputs();
        logic [127:0] w [NI];
        for (int j = 0; j < NI; j++) w[j] = (src_rd[j] != src_wr[j]) ? src_mem[j][src_rd[j]] : '0;
        bus0.in_empty = (src_rd[0] == src_wr[0]); bus0.in_dout = w[0][31:0];
        bus0.out_i_full = full_i[0]; bus0.out_q_full = full_q[0]; bus0.iq_swap = swap[0];
        bus1.in_empty = (src_rd[1] == src_wr[1]); bus1.in_dout = w[1][63:0];
        bus1.out_i_full = full_i[1]; bus1.out_q_full = full_q[1]; bus1.iq_swap = swap[1];
        bus2.in_empty = (src_rd[2] == src_wr[2]); bus2.in_dout = w[2];
        bus2.out_i_full = full_i[2]; bus2.out_q_full = full_q[2]; bus2.iq_swap = swap[2];
    endtask

    task automatic sample_outputs();
        obs_rd[0] = bus0.in_rd_en; obs_wi[0] = bus0.out_i_wr_en; obs_wq[0] = bus0.out_q_wr_en;
        obs_di[0] = bus0.out_i_din; obs_dq[0] = bus0.out_q_din; obs_cnt[0] = bus0.pair_count;
        obs_rd[1] = bus1.in_rd_en; obs_wi[1] = bus1.out_i_wr_en; obs_wq[1] = bus1.out_q_wr_en;
        obs_di[1] = bus1.out_i_din; obs_dq[1] = bus1.out_q_din; obs_cnt[1] = bus1.pair_count;
        obs_rd[2] = bus2.in_rd_en; obs_wi[2] = bus2.out_i_wr_en; obs_wq[2] = bus2.out_q_wr_en;
        obs_di[2] = bus2.out_i_din; obs_dq[2] = bus2.out_q_din; obs_cnt[2] = bus2.pair_count;
        for (int j = 0; j < NI; j++)
            obs_v[j] = {obs_rd[j], obs_wi[j], obs_wq[j], obs_di[j], obs_dq[j], obs_cnt[j]};
    endtask

    task automatic model_eval(input int j);
        int            rem;
        logic          ok;
        logic [OW-1:0] ei;
        logic [OW-1:0] eq;
        exp_rd[j] = 1'b0;
        exp_wr[j] = 1'b0;
        ei = '0;
        eq = '0;
        if (!reset) begin
            rem = pend_n[j] - pend_h[j];
            ok  = !full_i[j] && !full_q[j];
            exp_wr[j] = (rem > 0) && ok;
            if (exp_wr[j]) begin
                ei = pend_i[j][pend_h[j]];
                eq = pend_q[j][pend_h[j]];
            end
            exp_rd[j] = (src_rd[j] != src_wr[j]) && ((rem == 0) || (rem == 1 && ok));
        end
        exp_v[j] = {exp_rd[j], exp_wr[j], exp_wr[j], ei, eq, reset ? 32'd0 : mcount[j]};
    endtask

    task automatic model_commit(input int j);
        logic [127:0]  w;
        logic [31:0]   p;
        logic [OW-1:0] iv;
        logic [OW-1:0] qv;
        if (reset) begin
            pend_n[j] = 0;
            pend_h[j] = 0;
            mcount[j] = '0;
        end else begin
            if (exp_wr[j]) begin
                pend_h[j]++;
                mcount[j] = mcount[j] + 32'd1;
            end
            if (exp_rd[j]) begin
                w = src_mem[j][src_rd[j]];
                src_rd[j]++;
                for (int k = 0; k < pairs_of(j); k++) begin
                    p  = w[32*k +: 32];
                    iv = qval(byte_of(p, 2), byte_of(p, 3));
                    qv = qval(byte_of(p, 0), byte_of(p, 1));
                    pend_i[j][k] = swap[j] ? qv : iv;
                    pend_q[j][k] = swap[j] ? iv : qv;
                end
                pend_n[j] = pairs_of(j);
                pend_h[j] = 0;
            end
        end
    endtask

    // Called just after a falling edge: drive, settle, observe, predict.
    task automatic prep();
        drive_inputs();
        #1;
        sample_outputs();
        for (int j = 0; j < NI; j++) model_eval(j);
    endtask

    task automatic adv();
        @(posedge clock);
        for (int j = 0; j < NI; j++) model_commit(j);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        prep();
        for (int j = 0; j < NI; j++) begin
            checks++;
            if (obs_v[j] !== 99'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %h want 0", j, obs_v[j]);
            end
        end
        adv();
        adv();
        reset = 1'b0;
    endtask

    task automatic test_single_pair();
        int nwr = 0;
        push(0, 128'h3412CCFF);
        for (int c = 0; c < 4; c++) begin
            prep();
            checks++;
            if (obs_v[0] !== exp_v[0]) begin
                errors++;
                $display("FAIL single_pair c%0d: got %h want %h", c, obs_v[0], exp_v[0]);
            end
            if (obs_wi[0]) begin
                nwr++;
                checks++;
                if (obs_di[0] !== 32'd4771840 || obs_dq[0] !== 32'hFFFF3000) begin
                    errors++;
                    $display("FAIL single_pair_value: got I=%h Q=%h want I=0048d000 Q=ffff3000", obs_di[0], obs_dq[0]);
                end
            end
            adv();
        end
        prep();
        checks++;
        if (nwr != 1 || obs_cnt[0] !== 32'd1) begin
            errors++;
            $display("FAIL single_pair_count: got writes=%0d count=%0d want 1 and 1", nwr, obs_cnt[0]);
        end
        adv();
    endtask

    task automatic test_two_pair_word();
        int            nwr = 0;
        int            cyc [2];
        logic [OW-1:0] wi  [2];
        logic [OW-1:0] wq  [2];
        push(1, 128'h3412CCFF_01000200);
        for (int c = 0; c < 5; c++) begin
            prep();
            checks++;
            if (obs_v[1] !== exp_v[1]) begin
                errors++;
                $display("FAIL two_pair c%0d: got %h want %h", c, obs_v[1], exp_v[1]);
            end
            if (obs_wi[1] && nwr < 2) begin
                cyc[nwr] = c; wi[nwr] = obs_di[1]; wq[nwr] = obs_dq[1];
            end
            if (obs_wi[1]) nwr++;
            adv();
        end
        checks++;
        if (nwr != 2 || cyc[1] != cyc[0] + 1 || wi[0] !== 32'd1024 || wq[0] !== 32'd2048 ||
            wi[1] !== 32'd4771840 || wq[1] !== 32'hFFFF3000) begin
            errors++;
            $display("FAIL two_pair_values: got n=%0d I0=%0d Q0=%0d I1=%h Q1=%h want 2 1024 2048 0048d000 ffff3000",
                     nwr, wi[0], wq[0], wi[1], wq[1]);
        end
    endtask

    task automatic test_back_to_back();
        int nwr = 0;
        int nrd = 0;
        int first = -1;
        int last = -1;
        for (int n = 0; n < 8; n++) push(1, 128'({$urandom(), $urandom()}));
        for (int c = 0; c < 20; c++) begin
            prep();
            checks++;
            if (obs_v[1] !== exp_v[1]) begin
                errors++;
                $display("FAIL back_to_back c%0d: got %h want %h", c, obs_v[1], exp_v[1]);
            end
            if (obs_wi[1]) begin
                nwr++;
                if (first < 0) first = c;
                last = c;
            end
            if (obs_rd[1]) nrd++;
            adv();
        end
        checks++;
        if (nwr != 16 || last - first != 15 || nrd != 8) begin
            errors++;
            $display("FAIL back_to_back_rate: got writes=%0d span=%0d pops=%0d want 16 15 8", nwr, last - first, nrd);
        end
    endtask

    task automatic test_backpressure();
        int nwr = 0;
        push(1, 128'({$urandom(), $urandom()}));
        push(1, 128'({$urandom(), $urandom()}));
        for (int c = 0; c < 16; c++) begin
            full_q[1] = (c >= 2 && c < 7);
            prep();
            checks++;
            if (obs_v[1] !== exp_v[1]) begin
                errors++;
                $display("FAIL backpressure c%0d: got %h want %h", c, obs_v[1], exp_v[1]);
            end
            if (full_q[1]) begin
                checks++;
                if (obs_wi[1] || obs_wq[1] || obs_rd[1]) begin
                    errors++;
                    $display("FAIL backpressure_hold c%0d: got wi=%b wq=%b rd=%b want 0 0 0", c, obs_wi[1], obs_wq[1], obs_rd[1]);
                end
            end
            if (obs_wi[1]) nwr++;
            adv();
        end
        full_q[1] = 1'b0;
        checks++;
        if (nwr != 4) begin
            errors++;
            $display("FAIL backpressure_total: got %0d want 4", nwr);
        end
    endtask

    task automatic test_swap();
        logic seen = 1'b0;
        push(1, 128'h01000200_3412CCFF);
        for (int c = 0; c < 5; c++) begin
            swap[1] = (c == 0) ? 1'b1 : ~swap[1];
            prep();
            checks++;
            if (obs_v[1] !== exp_v[1]) begin
                errors++;
                $display("FAIL swap c%0d: got %h want %h", c, obs_v[1], exp_v[1]);
            end
            if (obs_wi[1] && !seen) begin
                seen = 1'b1;
                checks++;
                if (obs_di[1] !== 32'hFFFF3000 || obs_dq[1] !== 32'd4771840) begin
                    errors++;
                    $display("FAIL swap_value: got I=%h Q=%h want ffff3000 0048d000", obs_di[1], obs_dq[1]);
                end
            end
            adv();
        end
        swap[1] = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        int nwr = 0;
        push(2, {$urandom(), $urandom(), $urandom(), $urandom()});
        for (int c = 0; c < 2; c++) begin
            prep();
            checks++;
            if (obs_v[2] !== exp_v[2] || (c == 1 && !obs_wi[2])) begin
                errors++;
                $display("FAIL reset_mid_pre c%0d: got %h want %h", c, obs_v[2], exp_v[2]);
            end
            adv();
        end
        reset = 1'b1;
        prep();
        checks++;
        if (obs_wi[2] || obs_wq[2] || obs_rd[2] || obs_cnt[2] !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_drop: got wi=%b wq=%b rd=%b count=%0d want 0 0 0 0", obs_wi[2], obs_wq[2], obs_rd[2], obs_cnt[2]);
        end
        adv();
        reset = 1'b0;
        push(2, {$urandom(), $urandom(), $urandom(), 32'h3412CCFF});
        for (int c = 0; c < 8; c++) begin
            prep();
            checks++;
            if (obs_v[2] !== exp_v[2]) begin
                errors++;
                $display("FAIL reset_mid_post c%0d: got %h want %h", c, obs_v[2], exp_v[2]);
            end
            if (obs_wi[2] && nwr == 0) begin
                checks++;
                if (obs_di[2] !== 32'd4771840 || obs_cnt[2] !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_mid_restart: got I=%h count=%0d want 0048d000 0", obs_di[2], obs_cnt[2]);
                end
            end
            if (obs_wi[2]) nwr++;
            adv();
        end
        checks++;
        if (nwr != 4) begin
            errors++;
            $display("FAIL reset_mid_total: got %0d want 4", nwr);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 420; c++) begin
            for (int j = 0; j < NI; j++) begin
                full_i[j] = (c < 400) && ($urandom_range(3) == 0);
                full_q[j] = (c < 400) && ($urandom_range(3) == 0);
                swap[j]   = 1'($urandom_range(1));
                if (c < 400 && (src_wr[j] - src_rd[j]) < 3 && $urandom_range(1) == 1)
                    push(j, {$urandom(), $urandom(), $urandom(), $urandom()});
            end
            prep();
            for (int j = 0; j < NI; j++) begin
                checks++;
                if (obs_v[j] !== exp_v[j]) begin
                    errors++;
                    $display("FAIL random inst%0d c%0d: got %h want %h", j, c, obs_v[j], exp_v[j]);
                end
            end
            adv();
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int j = 0; j < NI; j++) begin
            src_rd[j] = 0; src_wr[j] = 0;
            full_i[j] = 1'b0; full_q[j] = 1'b0; swap[j] = 1'b0;
            pend_n[j] = 0; pend_h[j] = 0; mcount[j] = '0;
            exp_rd[j] = 1'b0; exp_wr[j] = 1'b0;
        end
        test_reset();
        test_single_pair();
        test_two_pair_word();
        test_back_to_back();
        test_backpressure();
        test_swap();
        test_reset_mid_word();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
